piezo_arbiter: RTL
==================

# piezo_arbiter

Shares the single piezo tone generator between several sound requesters, such as the intro riff player, game-event effects and alarm tones. The requesters present `play_en`/`pitch` pairs; this block picks one with fixed priority. It enforces a minimum hold time before a higher-priority source may pre-empt, and inserts a short silent gap on every source switch. Its registered `o_play_en`/`o_pitch` drive the piezo square-wave generator directly, and `o_pitch` carries the same counter-limit units (50 MHz / (2·f)).

## Interface
- `N_REQ`, 4, number of requesters; index 0 has the highest priority.
- `PITCH_W`, 32, width of each pitch (counter-limit) value.
- `MIN_HOLD_MS`, 20, ticks a grant is held before it can be pre-empted (≥1).
- `GAP_MS`, 5, silent ticks inserted on a source switch (≥1).

- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: synchronous, active-high reset.
- `i_tick` input 1: single-cycle 1 ms strobe.
- `i_req_en` input N_REQ: per-requester play request, level.
- `i_req_pitch` input N_REQ*PITCH_W: requester k's pitch in bits [k*PITCH_W +: PITCH_W].
- `i_mute` input 1: global mute.
- `o_play_en` output 1: piezo enable, registered.
- `o_pitch` output PITCH_W: piezo counter limit, registered.
- `o_grant` output N_REQ: one-hot current owner, or all-zero; registered.
- `o_busy` output 1: high in PLAY or GAP.

## Operation
- FSM states: IDLE, PLAY, GAP. State changes only on `clk` edges.
- **Outputs per state**
  - IDLE: `o_grant`=0, `o_play_en`=0, `o_pitch`=0.
  - PLAY: `o_grant` is one-hot at the owner. `o_pitch` follows the owner's `i_req_pitch` with one register stage. `o_play_en` = !`i_mute` && (owner pitch ≠ 0); a pitch of 0 is a rest and the grant is kept.
  - GAP: `o_grant`=0, `o_play_en`=0, `o_pitch`=0.
- **IDLE**: if any `i_req_en` is set, grant the lowest set index, go to PLAY and clear `hold_cnt`.
- **PLAY**
  - On `i_tick`, `hold_cnt` increments, saturating at MIN_HOLD_MS.
  - Owner's request drops and no other request is set: go to IDLE.
  - Owner's request drops and another request is set: go to GAP.
  - A lower-index request is set and `hold_cnt` == MIN_HOLD_MS: pre-empt and go to GAP.
  - A higher-index (lower-priority) request never pre-empts.
- **GAP**
  - On `i_tick`, `gap_cnt` increments.
  - When `gap_cnt` reaches GAP_MS, re-arbitrate over current requests. Grant the lowest set index and go to PLAY with `hold_cnt`=0; if no request is set, go to IDLE.
  - Requests that rise or fall during GAP are honoured only at GAP exit.
- **Mute**: `i_mute` does not affect arbitration or counters; it only gates `o_play_en`.
- **Counter widths**: `hold_cnt` and `gap_cnt` are $clog2(param+1) bits. `gap_cnt` is cleared on entry to GAP.

## Timing
- **Reset**: any cycle with `rst`=1 forces IDLE at the next edge. All outputs and counters go to 0, including mid-PLAY or mid-GAP.
- **Grant latency**:
  - Request seen in IDLE at edge n: `o_grant`/`o_play_en`/`o_pitch` valid after edge n+1.
  - Pitch change by the owner in PLAY: reflected 1 cycle later.
- **Release latency**: owner drop seen at edge n means outputs are 0 after edge n+1.
- **Hold window**: pre-emption is allowed from the cycle after the MIN_HOLD_MS-th tick since grant. A tick and a pre-empting request in the same cycle: the tick is counted first, so pre-emption happens if the post-increment count equals MIN_HOLD_MS.
- **Gap length**: GAP_MS full ticks, so the silence lasts between GAP_MS−1 ms and GAP_MS ms plus one cycle.
- **Simultaneous events**: owner drop and higher-priority rise in the same cycle go to GAP. A request that rises and falls within GAP is ignored.

## Configuration
- `PIEZO_ARB_GAP_EN`
  - Defined: behaviour as above.
  - Undefined: the GAP state is removed. Every transition into GAP instead grants the new owner directly in PLAY in the same cycle, with `hold_cnt`=0. `o_pitch` switches with no silent cycle. `GAP_MS` is ignored.

## Test plan
- Reset, then raise req2 with pitch 42565: after 1 cycle `o_grant`=4'b0100, `o_play_en`=1, `o_pitch`=42565. Drop req2: all outputs 0 one cycle later.
- req3 owning for 5 ticks, then req0 raised: no pre-emption until tick 20. Then GAP for 5 ticks with `o_play_en`=0, `o_busy`=1, after which `o_grant`=4'b0001.
- Owner req0 playing, req1 raised: req1 is never granted while req0 stays asserted. Drop req0: 5-tick gap, then req1 is granted.
- Owner pitch set to 0 mid-PLAY: `o_play_en`=0 and `o_grant` unchanged. `i_mute`=1: `o_play_en`=0 and the counters keep running.
- Assert `rst` for one cycle mid-GAP: IDLE next edge with all outputs 0. Re-arbitration resumes normally after reset.
- `PIEZO_ARB_GAP_EN` undefined: pre-emption after 20 ticks switches `o_pitch` in a single cycle with no zero cycle.

Source files
------------

// File: rtl/piezo_arbiter.sv
// rtl/piezo_arbiter.sv - fixed-priority arbiter sharing one piezo tone generator
// Define PIEZO_ARB_GAP_EN to insert a silent GAP on every source switch.
module piezo_arbiter #(
  parameter int N_REQ       = 4,
  parameter int PITCH_W     = 32,
  parameter int MIN_HOLD_MS = 20,
  parameter int GAP_MS      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_tick,
  input  logic [N_REQ-1:0]         i_req_en,
  input  logic [N_REQ*PITCH_W-1:0] i_req_pitch,
  input  logic                     i_mute,
  output logic                     o_play_en,
  output logic [PITCH_W-1:0]       o_pitch,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MIN_HOLD_MS + 1);
  localparam int GW = $clog2(GAP_MS + 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t         state, state_nxt;
  logic [OW-1:0]  owner, owner_nxt, first_idx;
  logic [HW-1:0]  hold_cnt, hold_nxt, hold_inc;
  logic [GW-1:0]  gap_cnt, gap_nxt, gap_inc;
  logic           any_req, hi_req, owner_req, switch_src;
  logic [N_REQ-1:0]   grant_nxt;
  logic [PITCH_W-1:0] pitch_nxt;
  logic               play_nxt;

  always_comb begin
    any_req   = |i_req_en;
    owner_req = i_req_en[owner];
    first_idx = '0;
    hi_req    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req_en[k]) first_idx = OW'(k);
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (k < int'(owner) && i_req_en[k]) hi_req = 1'b1;
    end
    hold_inc = (i_tick && hold_cnt != HW'(MIN_HOLD_MS)) ? hold_cnt + HW'(1) : hold_cnt;
    gap_inc  = i_tick ? gap_cnt + GW'(1) : gap_cnt;
    // The tick of this cycle counts before the pre-emption check.
    switch_src = !owner_req || (hi_req && hold_inc == HW'(MIN_HOLD_MS));
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = PLAY;
          owner_nxt = first_idx;
          hold_nxt  = '0;
        end
      end
      PLAY: begin
        hold_nxt = hold_inc;
        if (!owner_req && !any_req) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (switch_src) begin
`ifdef PIEZO_ARB_GAP_EN
          state_nxt = GAP;
          gap_nxt   = '0;
`else
          state_nxt = PLAY;
          owner_nxt = first_idx;
          hold_nxt  = '0;
`endif
        end
      end
      GAP: begin
        gap_nxt = gap_inc;
        if (gap_inc == GW'(GAP_MS)) begin
          gap_nxt  = '0;
          hold_nxt = '0;
          if (any_req) begin
            state_nxt = PLAY;
            owner_nxt = first_idx;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    grant_nxt = '0;
    pitch_nxt = '0;
    play_nxt  = 1'b0;
    if (state_nxt == PLAY) begin
      grant_nxt[owner_nxt] = 1'b1;
      pitch_nxt = i_req_pitch[int'(owner_nxt)*PITCH_W +: PITCH_W];
      play_nxt  = !i_mute && (pitch_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      o_grant   <= '0;
      o_pitch   <= '0;
      o_play_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      o_grant   <= grant_nxt;
      o_pitch   <= pitch_nxt;
      o_play_en <= play_nxt;
    end
  end

  assign o_busy = (state != IDLE);

endmodule
